// File: rtl/vga_timing_param_if.sv
// Video timing bundle between the timing generator and the draw pipeline.
// The generator drives counts, syncs, blanks and frame markers; the consumer drives the pixel enable.
interface vga_timing_param_if #(
  parameter int unsigned CNT_W   = 11,
  parameter int unsigned FRAME_W = 8
);
  logic               en;
  logic [CNT_W-1:0]   hcount;
  logic [CNT_W-1:0]   vcount;
  logic               hsync;
  logic               vsync;
  logic               hblnk;
  logic               vblnk;
  logic               de;
  logic               sof;
  logic [FRAME_W-1:0] frame_cnt;

  modport master (
    input  en,
    output hcount, vcount, hsync, vsync, hblnk, vblnk, de, sof, frame_cnt
  );

  modport slave (
    output en,
    input  hcount, vcount, hsync, vsync, hblnk, vblnk, de, sof, frame_cnt
  );
endinterface

// File: rtl/vga_timing_param.sv
// Parametrised VGA timing generator: free-running h/v counters with a stall enable,
// registered sync/blank/de decode aligned to the counts, start-of-frame pulse and frame counter.
module vga_timing_param #(
  parameter int unsigned H_ACTIVE   = 1024,
  parameter int unsigned H_FP       = 24,
  parameter int unsigned H_SYNC     = 136,
  parameter int unsigned H_BP       = 160,
  parameter int unsigned V_ACTIVE   = 768,
  parameter int unsigned V_FP       = 3,
  parameter int unsigned V_SYNC     = 6,
  parameter int unsigned V_BP       = 29,
  parameter bit          H_SYNC_POL = 1'b0,
  parameter bit          V_SYNC_POL = 1'b0,
  parameter int unsigned CNT_W      = 11,
  parameter int unsigned FRAME_W    = 8
) (
  input  logic                clk,
  input  logic                rst,
  vga_timing_param_if.master  vif
);

  localparam int unsigned H_TOT    = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOT    = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HS_START = H_ACTIVE + H_FP;
  localparam int unsigned HS_END   = HS_START + H_SYNC;
  localparam int unsigned VS_START = V_ACTIVE + V_FP;
  localparam int unsigned VS_END   = VS_START + V_SYNC;

  // Reject degenerate timings and counters too narrow for the frame.
  if (H_ACTIVE == 0 || H_FP == 0 || H_SYNC == 0 || H_BP == 0 ||
      V_ACTIVE == 0 || V_FP == 0 || V_SYNC == 0 || V_BP == 0 ||
      CNT_W == 0 || FRAME_W == 0) begin : g_bad_width
    $error("vga_timing_param: every width parameter must be >= 1");
  end
  if (CNT_W < 32 && (H_TOT > (32'd1 << CNT_W) || V_TOT > (32'd1 << CNT_W))) begin : g_bad_cnt_w
    $error("vga_timing_param: H_TOT-1 or V_TOT-1 does not fit in CNT_W bits");
  end
  if ($bits(vif.hcount) != CNT_W || $bits(vif.frame_cnt) != FRAME_W) begin : g_bad_if
    $error("vga_timing_param: interface widths do not match CNT_W/FRAME_W");
  end

  logic [CNT_W-1:0]   h_q, v_q, h_nxt, v_nxt;
  logic [FRAME_W-1:0] frame_q;
  logic               frame_wrap;
  logic               hsync_q, vsync_q, hblnk_q, vblnk_q, de_q, sof_q;
  logic               hsync_nxt, vsync_nxt, hblnk_nxt, vblnk_nxt;
  logic [31:0]        hn, vn;

  // Next counter values; decode uses these so outputs line up with the registered counts.
  always_comb begin
    h_nxt      = h_q;
    v_nxt      = v_q;
    frame_wrap = 1'b0;
    if (vif.en) begin
      if (h_q == CNT_W'(H_TOT - 1)) begin
        h_nxt = '0;
        if (v_q == CNT_W'(V_TOT - 1)) begin
          v_nxt      = '0;
          frame_wrap = 1'b1;
        end else begin
          v_nxt = v_q + CNT_W'(1);
        end
      end else begin
        h_nxt = h_q + CNT_W'(1);
      end
    end
  end

  // Region decode done in 32 bits so an end bound equal to 2**CNT_W still compares correctly.
  always_comb begin
    hn        = 32'(h_nxt);
    vn        = 32'(v_nxt);
    hblnk_nxt = (hn >= H_ACTIVE);
    vblnk_nxt = (vn >= V_ACTIVE);
    hsync_nxt = ((hn >= HS_START) && (hn < HS_END)) ? H_SYNC_POL : ~H_SYNC_POL;
    vsync_nxt = ((vn >= VS_START) && (vn < VS_END)) ? V_SYNC_POL : ~V_SYNC_POL;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_q     <= '0;
      v_q     <= '0;
      frame_q <= '0;
      sof_q   <= 1'b0;
      hblnk_q <= 1'b0;
      vblnk_q <= 1'b0;
      de_q    <= 1'b1;
      hsync_q <= ~H_SYNC_POL;
      vsync_q <= ~V_SYNC_POL;
    end else begin
      h_q     <= h_nxt;
      v_q     <= v_nxt;
      sof_q   <= frame_wrap;
      hblnk_q <= hblnk_nxt;
      vblnk_q <= vblnk_nxt;
      de_q    <= ~hblnk_nxt & ~vblnk_nxt;
      hsync_q <= hsync_nxt;
      vsync_q <= vsync_nxt;
      if (frame_wrap) begin
        frame_q <= frame_q + FRAME_W'(1);
      end
    end
  end

  assign vif.hcount    = h_q;
  assign vif.vcount    = v_q;
  assign vif.hsync     = hsync_q;
  assign vif.vsync     = vsync_q;
  assign vif.hblnk     = hblnk_q;
  assign vif.vblnk     = vblnk_q;
  assign vif.de        = de_q;
  assign vif.sof       = sof_q;
  assign vif.frame_cnt = frame_q;

endmodule
